// File: rtl/sha2_pkg.sv
// Shared constants, state encoding and SHA-2 bit functions for the streaming core.
package sha2_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [0:7][31:0]  hvec_t;   // element 0 = H0 / a, packs into the MSBs
  typedef logic [0:15][31:0] wwin_t;   // element 0 = W_t, oldest word of the window

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hvec_t IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam hvec_t IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha2_stream_core_if.sv
// Block-in / digest-out handshake bundle of the streaming SHA-2 core.
interface sha2_stream_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         mode_224;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] dig_data;
  logic         busy;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last, mode_224, dig_ready,
    input  blk_ready, dig_valid, dig_data, busy
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, mode_224, dig_ready,
    output blk_ready, dig_valid, dig_data, busy
  );
endinterface

// File: rtl/sha2_round.sv
// One SHA-2 compression round plus one message-schedule step, purely combinational.
module sha2_round
  import sha2_pkg::*;
(
  input  hvec_t st_in,
  input  wwin_t w_in,
  input  word_t k,
  output hvec_t st_out,
  output wwin_t w_out
);

  word_t t1_s;
  word_t t2_s;
  word_t w_new_s;

  // round arithmetic and next schedule word W_t+16
  always_comb begin
    t1_s    = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k + w_in[0];
    t2_s    = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
    w_new_s = small_sigma1(w_in[14]) + w_in[9] + small_sigma0(w_in[1]) + w_in[0];
    st_out  = {t1_s + t2_s, st_in[0], st_in[1], st_in[2],
               st_in[3] + t1_s, st_in[4], st_in[5], st_in[6]};
    w_out   = {w_in[1:15], w_new_s};
  end

endmodule

// File: rtl/sha2_stream_core.sv
// Streaming SHA-256/224 core: FSM, chaining state and UNROLL chained round lanes.
module sha2_stream_core
  import sha2_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          clk,
  input  logic          reset,
  sha2_stream_if.slave  s
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha2_stream_core: UNROLL must be 1, 2 or 4");
  end

  state_e      state_r, state_nxt_s;
  hvec_t       h_r, work_r, h_next_s, iv_s;
  wwin_t       w_r;
  logic [5:0]  rnd_r;
  logic        open_r, mode_r, last_r;
  logic [255:0] dig_r;
  logic        blk_ready_s, dig_valid_s, busy_s;

  hvec_t       st_s [0:UNROLL];
  wwin_t       w_s  [0:UNROLL];

  assign st_s[0] = work_r;
  assign w_s[0]  = w_r;

  for (genvar l = 0; l < UNROLL; l++) begin : g_lane
    sha2_round u_round (
      .st_in  (st_s[l]),
      .w_in   (w_s[l]),
      .k      (K[rnd_r + 6'(l)]),
      .st_out (st_s[l+1]),
      .w_out  (w_s[l+1])
    );
  end

  // IV choice and chaining-value update
  always_comb begin
    iv_s     = s.mode_224 ? IV224 : IV256;
    h_next_s = h_r;
    for (int i = 0; i < 8; i++) begin
      h_next_s[i] = h_r[i] + work_r[i];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (s.blk_valid) state_nxt_s = ST_ROUND; else state_nxt_s = ST_IDLE;
      ST_ROUND:  if (rnd_r == 6'(64 - UNROLL)) state_nxt_s = ST_UPDATE; else state_nxt_s = ST_ROUND;
      ST_UPDATE: if (last_r) state_nxt_s = ST_OUT; else state_nxt_s = ST_IDLE;
      ST_OUT:    if (s.dig_ready) state_nxt_s = ST_IDLE; else state_nxt_s = ST_OUT;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from the state register alone
  always_comb begin
    blk_ready_s = 1'b0;
    dig_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE:   blk_ready_s = 1'b1;
      ST_ROUND:  busy_s      = 1'b1;
      ST_UPDATE: busy_s      = 1'b1;
      ST_OUT:    dig_valid_s = 1'b1;
      default:   blk_ready_s = 1'b0;
    endcase
  end

  // datapath: block load, round iteration, chaining update and digest capture
  always_ff @(posedge clk) begin
    if (reset) begin
      h_r    <= '0;
      work_r <= '0;
      w_r    <= '0;
      rnd_r  <= 6'd0;
      open_r <= 1'b0;
      mode_r <= 1'b0;
      last_r <= 1'b0;
      dig_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (s.blk_valid) begin
            w_r    <= s.blk_data;
            last_r <= s.blk_last;
            rnd_r  <= 6'd0;
            // a first block, or any block with no open message, restarts from IV
            if (s.blk_first || !open_r) begin
              h_r    <= iv_s;
              work_r <= iv_s;
              mode_r <= s.mode_224;
              open_r <= 1'b1;
            end else begin
              work_r <= h_r;
            end
          end
        end
        ST_ROUND: begin
          work_r <= st_s[UNROLL];
          w_r    <= w_s[UNROLL];
          rnd_r  <= rnd_r + 6'(UNROLL);
        end
        ST_UPDATE: begin
          h_r <= h_next_s;
          if (last_r) begin
            dig_r  <= mode_r ? {h_next_s[0:6], 32'h0000_0000} : h_next_s;
            open_r <= 1'b0;
          end
        end
        default: begin
          dig_r <= dig_r;
        end
      endcase
    end
  end

  assign s.blk_ready = blk_ready_s;
  assign s.dig_valid = dig_valid_s;
  assign s.busy      = busy_s;
  assign s.dig_data  = dig_r;

endmodule

// File: tb/tb_sha2_stream_core.sv
// Scoreboard bench: three cores (UNROLL 1/2/4) checked against known digests and a SHA-2 model.
module tb_sha2_stream_core;
  import sha2_pkg::K;
  import sha2_pkg::IV256;
  import sha2_pkg::IV224;

  logic         clk;
  logic         reset;
  logic         blk_valid, blk_first, blk_last, mode_224, dig_ready;
  logic [511:0] blk_data;
  int           sel;
  int           cyc;
  int           nvec, nerr;

  logic [2:0]   dv_s, br_s, bz_s;
  logic [255:0] dd_s [0:2];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha2_stream_if bus ();
    assign bus.blk_valid = blk_valid && (sel == g);
    assign bus.blk_data  = blk_data;
    assign bus.blk_first = blk_first;
    assign bus.blk_last  = blk_last;
    assign bus.mode_224  = mode_224;
    assign bus.dig_ready = dig_ready;
    assign dv_s[g] = bus.dig_valid;
    assign br_s[g] = bus.blk_ready;
    assign bz_s[g] = bus.busy;
    assign dd_s[g] = bus.dig_data;
    sha2_stream_core #(.UNROLL(1 << g)) u_dut (.clk(clk), .reset(reset), .s(bus));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [255:0] dig; int acc; int n; } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // reference compression: full 64-word schedule, then 64 rounds
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [0:63];
    logic [31:0] v [0:7];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // monitor: latency on dig_valid rise, digest compare on each transfer
  logic prev_dv;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_dv = 1'b0;
    end else begin
      if (dv_s[sel] && !prev_dv) begin
        if (q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_digest: got dig_valid=1 expected no pending digest (core %0d)", sel);
        end else begin
          chk("dig_valid_latency", 256'(cyc - q[0].acc), 256'(q[0].n + 2));
        end
      end
      if (dv_s[sel] && dig_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("dig_data", dd_s[sel], e.dig);
      end
      prev_dv = dv_s[sel];
    end
  end

  // present one block; entered just after a rising edge
  task automatic send(input logic [511:0] d, input logic f, input logic l, input logic m,
                      input logic [255:0] expd, input logic push);
    int k, acc, n;
    n = 64 / (1 << sel);
    blk_data = d; blk_first = f; blk_last = l; mode_224 = m; blk_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!br_s[sel] && k < 1000) begin @(negedge clk); k++; end
    if (!br_s[sel]) begin
      chk("blk_ready_timeout", 256'(br_s[sel]), 256'd1);
      blk_valid = 1'b0;
      return;
    end
    acc = cyc;
    if (push) q.push_back('{expd, acc, n});
    @(posedge clk); #1;
    blk_valid = 1'b0;
    blk_data = {16{$urandom()}};
    if (!l) begin
      k = 0;
      @(negedge clk);
      while (!br_s[sel] && k < 1000) begin @(negedge clk); k++; end
      chk("blk_ready_relatency", 256'(cyc - acc), 256'(n + 2));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 2000) begin @(negedge clk); k++; end
    chk("drain_queue_empty", 256'(q.size()), 256'd0);
    @(posedge clk); #1;
  endtask

  localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic dr_rand;

  // random consumer back-pressure while enabled
  initial begin
    dr_rand = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dr_rand) dig_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] b_abc, b_empty, b_two1, b_two2, d;
    logic [447:0] msg;
    logic [255:0] h, e;
    logic m, f, l;
    int nb;
    nvec = 0; nerr = 0; sel = 0;
    reset = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    mode_224 = 1'b0; dig_ready = 1'b1; blk_data = '0;
    b_abc   = {32'h61626380, 448'h0, 32'h00000018};
    b_empty = {32'h80000000, 480'h0};
    msg     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    b_two1  = {msg, 32'h80000000, 32'h0};
    b_two2  = {480'h0, 32'h000001c0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_blk_ready", 256'(br_s[g]), 256'd1);
      chk("reset_dig_valid", 256'(dv_s[g]), 256'd0);
      chk("reset_busy",      256'(bz_s[g]), 256'd0);
      chk("reset_dig_data",  dd_s[g], 256'd0);
    end
    @(posedge clk); #1;

    sel = 0; send(b_abc, 1'b1, 1'b1, 1'b0, D_ABC256, 1'b1); drain();
    sel = 2; send(b_abc, 1'b1, 1'b1, 1'b1, D_ABC224, 1'b1); drain();
    sel = 1;
    send(b_two1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) @(posedge clk); #1;
    send(b_two2, 1'b0, 1'b1, 1'b1, D_TWO, 1'b1);
    drain();

    // consumer stalls: digest must hold while blk_ready stays low
    sel = 0; dig_ready = 1'b0;
    send(b_empty, 1'b1, 1'b1, 1'b0, D_EMPTY, 1'b1);
    for (int k = 0; k < 200 && !dv_s[sel]; k++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_dig_valid", 256'(dv_s[sel]), 256'd1);
      chk("hold_blk_ready", 256'(br_s[sel]), 256'd0);
      chk("hold_dig_data",  dd_s[sel], D_EMPTY);
    end
    @(posedge clk); #1 dig_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("after_xfer_dig_valid", 256'(dv_s[sel]), 256'd0);
    chk("after_xfer_blk_ready", 256'(br_s[sel]), 256'd1);
    chk("after_xfer_queue", 256'(q.size()), 256'd0);
    @(posedge clk); #1;

    // abandon an open message with a new first block
    sel = 1;
    send(b_two1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    send(b_abc, 1'b1, 1'b1, 1'b0, D_ABC256, 1'b1);
    drain();

    // reset in the middle of ROUND drops the work
    sel = 0;
    send(b_abc, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("busy_in_round", 256'(bz_s[sel]), 256'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_blk_ready", 256'(br_s[sel]), 256'd1);
    chk("midreset_dig_valid", 256'(dv_s[sel]), 256'd0);
    chk("midreset_busy",      256'(bz_s[sel]), 256'd0);
    chk("midreset_dig_data",  dd_s[sel], 256'd0);
    @(posedge clk); #1;
    send(b_abc, 1'b0, 1'b1, 1'b0, D_ABC256, 1'b1);
    drain();

    // random multi-block messages on random cores with random back-pressure
    dr_rand = 1'b1;
    for (int r = 0; r < 24; r++) begin
      sel = $urandom_range(0, 2);
      nb  = $urandom_range(1, 3);
      m   = 1'($urandom_range(0, 1));
      h   = m ? IV224 : IV256;
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) d[511 - 32*i -: 32] = $urandom();
        h = compress(h, d);
        l = (b == nb - 1);
        f = (b == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        e = m ? {h[255:32], 32'h0} : h;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send(d, f, l, (b == 0) ? m : 1'($urandom_range(0, 1)), e, l);
      end
      drain();
    end
    dr_rand = 1'b0;

    repeat (5) @(posedge clk);
    chk("final_queue_empty", 256'(q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
